// File: rtl/mul_accum_if.sv
// Stream bundle between the product source, the group accumulator and the
// consumer of completed sums.
interface mul_accum_if #(
  parameter int N     = 4,
  parameter int ACC_W = 2 * N + 2
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output flush, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  flush, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mul_accum.sv
// Sums each group of LEN unsigned products and presents the total through a
// one-entry valid/ready output buffer; accumulation of the next group overlaps.
module mul_accum #(
  parameter int N     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 2 * N + 2
) (
  input  logic         clk,
  input  logic         rst,
  mul_accum_if.slave   bus
);

  localparam int                CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

  buf_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             last;
  logic             in_beat;
  logic             out_beat;
  logic             complete;

  // One extra bit captures the carry out of the accumulator width.
  assign sum_ext  = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_prod);
  assign carry    = sum_ext[ACC_W];
  assign last     = (cnt_q == CNT_LAST);
  assign in_beat  = bus.in_valid && bus.in_ready;
  assign out_beat = (state_q == BUF_FULL) && bus.out_ready;
  assign complete = in_beat && last && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUF_EMPTY;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;

    case (state_q)
      BUF_EMPTY: if (complete) state_d = BUF_FULL;
      BUF_FULL:  if (out_beat && !complete) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase

    // flush wins over any beat in the same cycle, including a completing one.
    if (bus.flush) begin
      acc_d     = '0;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (in_beat) begin
      if (last) begin
        acc_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
        sum_d     = sum_ext[ACC_W-1:0];
        ovf_d     = ovf_acc_q | carry;
      end else begin
        acc_d     = sum_ext[ACC_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        ovf_acc_d = ovf_acc_q | carry;
      end
    end
  end

  // Only the group's final beat can stall: it needs the output buffer.
  always_comb begin
    bus.out_valid = (state_q == BUF_FULL);
    bus.in_ready  = !(last && (state_q == BUF_FULL) && !bus.out_ready);
    bus.out_sum   = sum_q;
    bus.out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_mul_accum.sv
// Self-checking bench for mul_accum: table of groups plus hand-written stall,
// flush, wrap and reset sequences, with a scoreboard on the output stream.
module tb_mul_accum;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mul_accum_if #(.N(4), .ACC_W(10)) bus ();
  mul_accum_if #(.N(4), .ACC_W(9))  bus9 ();

  mul_accum #(.N(4), .LEN(4), .ACC_W(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mul_accum #(.N(4), .LEN(4), .ACC_W(9)) u_dut9 (
    .clk (clk),
    .rst (rst),
    .bus (bus9.slave)
  );

  typedef struct packed {
    logic [9:0] sum;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0] prod;
    logic [9:0]      sum;
    logic            ovf;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [9:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // One input beat; returns how many cycles the beat waited on in_ready.
  task automatic send(input logic [7:0] p, output int stalls);
    stalls       = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    @(negedge clk);
    while (!bus.in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at %0d, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] p, input int n);
    int st;
    for (int i = 0; i < n; i++) send(p, st);
  endtask

  // Scoreboard: an output beat happens at the next rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got result sum=%0d, expected no result", bus.out_sum);
      end else begin
        e = exp_q.pop_front();
        $display("RESULT sum=%0d ovf=%0d (expected sum=%0d ovf=%0d)",
                 bus.out_sum, bus.out_ovf, e.sum, e.ovf);
        check("sb_sum", 32'(bus.out_sum), 32'(e.sum));
        check("sb_ovf", 32'(bus.out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    int st;

    vecs[0] = '{prod: {8'd4,   8'd3,   8'd2,   8'd1},   sum: 10'd10,   ovf: 1'b0};
    vecs[1] = '{prod: {8'd225, 8'd225, 8'd225, 8'd225}, sum: 10'd900,  ovf: 1'b0};
    vecs[2] = '{prod: {8'd225, 8'd225, 8'd225, 8'd225}, sum: 10'd900,  ovf: 1'b0};
    vecs[3] = '{prod: {8'd0,   8'd0,   8'd0,   8'd0},   sum: 10'd0,    ovf: 1'b0};
    vecs[4] = '{prod: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 10'd1020, ovf: 1'b0};
    vecs[5] = '{prod: {8'd200, 8'd255, 8'd255, 8'd255}, sum: 10'd965,  ovf: 1'b0};
    vecs[6] = '{prod: {8'd100, 8'd9,   8'd0,   8'd7},   sum: 10'd116,  ovf: 1'b0};

    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_prod    = '0;
    bus.out_ready  = 1'b0;
    bus9.flush     = 1'b0;
    bus9.in_valid  = 1'b0;
    bus9.in_prod   = '0;
    bus9.out_ready = 1'b1;
    rst            = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_sum",   32'(bus.out_sum),   0);
    check("rst_out_ovf",   32'(bus.out_ovf),   0);
    check("rst_in_ready",  32'(bus.in_ready),  1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic group and result latency
    bus.out_ready = 1'b1;
    push_exp(10'd10, 1'b0);
    send(8'd1, st);
    send(8'd2, st);
    send(8'd3, st);
    check("lat_before_last", 32'(bus.out_valid), 0);
    send(8'd4, st);
    check("lat_valid", 32'(bus.out_valid), 1);
    check("lat_sum",   32'(bus.out_sum),   10);
    tick();
    check("lat_valid_drop", 32'(bus.out_valid), 0);

    // Table of groups at full rate; none may stall with out_ready=1
    for (int i = 0; i < 7; i++) begin
      push_exp(vecs[i].sum, vecs[i].ovf);
      for (int k = 0; k < 4; k++) begin
        send(vecs[i].prod[k], st);
        check("tbl_stall", 32'(st), 0);
      end
    end
    tick();
    tick();

    // Back-pressure: result held, only the last beat of the next group stalls
    bus.out_ready = 1'b0;
    push_exp(10'd4, 1'b0);
    push_exp(10'd8, 1'b0);
    send_n(8'd1, 4);
    send_n(8'd2, 3);
    check("bp_valid_held", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'd2;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_sum_held", 32'(bus.out_sum),  4);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_valid_next", 32'(bus.out_valid), 1);
    check("bp_sum_next",   32'(bus.out_sum),   8);
    tick();

    // flush discards a partial group
    send(8'd5, st);
    send(8'd6, st);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    push_exp(10'd4, 1'b0);
    send_n(8'd1, 4);
    tick();
    // flush coinciding with the completing beat
    send_n(8'd1, 3);
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'd1;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_last_no_result", 32'(bus.out_valid), 0);
    push_exp(10'd12, 1'b0);
    send_n(8'd3, 4);
    tick();
    tick();

    // Narrow accumulator wraps and flags the carry
    for (int i = 0; i < 4; i++) begin
      bus9.in_valid = 1'b1;
      bus9.in_prod  = 8'd225;
      tick();
    end
    bus9.in_valid = 1'b0;
    $display("RESULT9 sum=%0d ovf=%0d", bus9.out_sum, bus9.out_ovf);
    check("wrap_valid", 32'(bus9.out_valid), 1);
    check("wrap_sum",   32'(bus9.out_sum),   388);
    check("wrap_ovf",   32'(bus9.out_ovf),   1);
    for (int i = 0; i < 4; i++) begin
      bus9.in_valid = 1'b1;
      bus9.in_prod  = 8'd1;
      tick();
    end
    bus9.in_valid = 1'b0;
    $display("RESULT9 sum=%0d ovf=%0d", bus9.out_sum, bus9.out_ovf);
    check("wrap_next_sum", 32'(bus9.out_sum), 4);
    check("wrap_next_ovf", 32'(bus9.out_ovf), 0);

    // Asynchronous reset mid-group with a pending result
    bus.out_ready = 1'b0;
    send_n(8'd2, 4);
    send_n(8'd7, 2);
    check("arst_pre_valid", 32'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_out_sum",   32'(bus.out_sum),   0);
    check("arst_out_ovf",   32'(bus.out_ovf),   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push_exp(10'd12, 1'b0);
    send_n(8'd3, 4);
    check("arst_after_sum", 32'(bus.out_sum), 12);
    tick();
    tick();

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
